// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: one immediate extender shared by two requesters.
// Round-robin arbitration feeds a single-entry output register with a valid/ready handshake.
// A result can drain and a new one load on the same edge, so throughput is one per cycle.
module imm_ext_arbiter #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqA_Valid,
  input  logic [IN_W-1:0]  ReqA_Imm,
  input  logic [1:0]       ReqA_Mode,
  output logic             ReqA_Ready,
  input  logic             ReqB_Valid,
  input  logic [IN_W-1:0]  ReqB_Imm,
  input  logic [1:0]       ReqB_Mode,
  output logic             ReqB_Ready,
  output logic             Out_Valid,
  output logic [OUT_W-1:0] Out_Data,
  output logic             Out_Id,
  input  logic             Out_Ready
);

  localparam logic [1:0] ModeSext   = 2'b00;
  localparam logic [1:0] ModeZext   = 2'b01;
  localparam logic [1:0] ModeUpper  = 2'b10;
  localparam logic [1:0] ModeBranch = 2'b11;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_id_q;
  // Most recently granted requester; resets to B so that A wins the first contention.
  logic             last_q;

  logic             grant_b;
  logic             any_req;
  logic             can_accept;
  logic             accept;
  logic [IN_W-1:0]  sel_imm;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext_data;

  // Grant selection and handshake: under contention the requester other than last_q wins.
  always_comb begin
    grant_b    = ReqB_Valid && (!ReqA_Valid || !last_q);
    any_req    = ReqA_Valid || ReqB_Valid;
    can_accept = (state_q == StEmpty) || Out_Ready;
    accept     = any_req && can_accept;
    ReqA_Ready = ReqA_Valid && !grant_b && can_accept;
    ReqB_Ready = grant_b && can_accept;
  end

  // Extend the granted requester's immediate according to its mode.
  always_comb begin
    sel_imm  = grant_b ? ReqB_Imm  : ReqA_Imm;
    sel_mode = grant_b ? ReqB_Mode : ReqA_Mode;
    ext_data = '0;
    unique case (sel_mode)
      ModeSext:   ext_data = {{(OUT_W - IN_W){sel_imm[IN_W-1]}}, sel_imm};
      ModeZext:   ext_data = {{(OUT_W - IN_W){1'b0}}, sel_imm};
      ModeUpper:  ext_data = {sel_imm, {(OUT_W - IN_W){1'b0}}};
      ModeBranch: ext_data = {{(OUT_W - IN_W - 2){sel_imm[IN_W-1]}}, sel_imm, 2'b00};
      default:    ext_data = '0;
    endcase
  end

  // Output register FSM: load on accept, empty on a drain without a replacement.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      out_id_q   <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q    <= StFull;
            out_data_q <= ext_data;
            out_id_q   <= grant_b;
            last_q     <= grant_b;
          end
        end
        StFull: begin
          if (accept) begin
            // Drain and reload on the same edge: no bubble.
            out_data_q <= ext_data;
            out_id_q   <= grant_b;
            last_q     <= grant_b;
          end else if (Out_Ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign Out_Valid = (state_q == StFull);
  assign Out_Data  = out_data_q;
  assign Out_Id    = out_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: a reference model drives a scoreboard queue.
module tb_imm_ext_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ReqA_Valid, ReqB_Valid, ReqA_Ready, ReqB_Ready;
  logic [15:0] ReqA_Imm, ReqB_Imm;
  logic [1:0]  ReqA_Mode, ReqB_Mode;
  logic        Out_Valid, Out_Id, Out_Ready;
  logic [31:0] Out_Data;

  always #5 Clk = ~Clk;

  imm_ext_arbiter #(
    .IN_W (16),
    .OUT_W(32)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .ReqA_Valid(ReqA_Valid),
    .ReqA_Imm  (ReqA_Imm),
    .ReqA_Mode (ReqA_Mode),
    .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid),
    .ReqB_Imm  (ReqB_Imm),
    .ReqB_Mode (ReqB_Mode),
    .ReqB_Ready(ReqB_Ready),
    .Out_Valid (Out_Valid),
    .Out_Data  (Out_Data),
    .Out_Id    (Out_Id),
    .Out_Ready (Out_Ready)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        model_valid;
  logic        model_last;
  logic [31:0] model_held;
  logic        model_held_id;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Reference extension written arithmetically rather than by bit concatenation.
  function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = 32'($signed(imm));
    case (mode)
      2'd0:    return s;
      2'd1:    return {16'h0, imm};
      2'd2:    return {imm, 16'h0};
      default: return s * 4;
    endcase
  endfunction

  task automatic model_reset();
    model_valid   = 1'b0;
    model_last    = 1'b1;
    model_held    = 32'h0;
    model_held_id = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle: inputs applied just after a rising edge, checks on the falling edge.
  task automatic step(input logic av, input logic [15:0] ai, input logic [1:0] am,
                      input logic bv, input logic [15:0] bi, input logic [1:0] bm,
                      input logic ordy, output logic acc_a, output logic acc_b);
    logic gb, can_acc, acc;
    exp_t e;
    ReqA_Valid = av; ReqA_Imm = ai; ReqA_Mode = am;
    ReqB_Valid = bv; ReqB_Imm = bi; ReqB_Mode = bm;
    Out_Ready  = ordy;
    @(negedge Clk);
    gb      = bv && (!av || !model_last);
    can_acc = !model_valid || ordy;
    acc     = (av || bv) && can_acc;
    acc_a   = acc && !gb;
    acc_b   = acc && gb;
    check_eq("a_ready", 32'(ReqA_Ready), 32'(acc_a));
    check_eq("b_ready", 32'(ReqB_Ready), 32'(acc_b));
    check_eq("out_valid", 32'(Out_Valid), 32'(model_valid));
    if (model_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got result %h with no expected entry", Out_Data);
      end else begin
        check_eq("out_data", Out_Data, sb_q[0].data);
        check_eq("out_id", 32'(Out_Id), 32'(sb_q[0].id));
        if (ordy) void'(sb_q.pop_front());
      end
    end else begin
      check_eq("held_data", Out_Data, model_held);
      check_eq("held_id", 32'(Out_Id), 32'(model_held_id));
    end
    if (acc) begin
      e.id   = gb;
      e.data = gb ? ext_model(bi, bm) : ext_model(ai, am);
      sb_q.push_back(e);
      model_held    = e.data;
      model_held_id = gb;
      model_last    = gb;
      model_valid   = 1'b1;
    end else if (model_valid && ordy) begin
      model_valid = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic id);
    check_eq({tag, "_valid"}, 32'(Out_Valid), 32'(v));
    check_eq({tag, "_data"}, Out_Data, d);
    check_eq({tag, "_id"}, 32'(Out_Id), 32'(id));
  endtask

  initial begin
    logic        xa, xb;
    logic        pa, pb;
    logic [15:0] ia, ib;
    logic [1:0]  ma, mb;

    // Reset with toggling inputs.
    Rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ReqA_Valid = 1'($urandom); ReqA_Imm = 16'($urandom); ReqA_Mode = 2'($urandom);
      ReqB_Valid = 1'($urandom); ReqB_Imm = 16'($urandom); ReqB_Mode = 2'($urandom);
      Out_Ready  = 1'($urandom);
      @(negedge Clk);
      expect_out("rst", 1'b0, 32'h0, 1'b0);
    end
    ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;
    #1;
    check_eq("rst_a_ready", 32'(ReqA_Ready), 32'd0);
    check_eq("rst_b_ready", 32'(ReqB_Ready), 32'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    model_reset();

    // Mode coverage.
    step(1'b1, 16'h8001, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    expect_out("sext", 1'b1, 32'hFFFF8001, 1'b0);
    step(1'b0, 16'h0, 2'b00, 1'b1, 16'h8001, 2'b01, 1'b1, xa, xb);
    expect_out("zext", 1'b1, 32'h00008001, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 16'h8001, 2'b10, 1'b1, xa, xb);
    expect_out("upper", 1'b1, 32'h80010000, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 16'hFFFF, 2'b11, 1'b1, xa, xb);
    expect_out("br_neg", 1'b1, 32'hFFFFFFFC, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b1, 16'h0004, 2'b11, 1'b1, xa, xb);
    expect_out("br_pos", 1'b1, 32'h00000010, 1'b1);

    // Idle drain: valid falls, data retained.
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    expect_out("idle", 1'b0, 32'h00000010, 1'b1);
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);

    // Contention: strict alternation starting with A.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1, xa, xb);
      expect_out("contend", 1'b1, (i % 2 == 0) ? 32'd1 : 32'd2, (i % 2 != 0));
    end
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);

    // Backpressure, then drain and accept on the same edge.
    step(1'b1, 16'h1234, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h5555, 2'b01, 1'b1, 16'h00F0, 2'b10, 1'b0, xa, xb);
      expect_out("bp_hold", 1'b1, 32'h00001234, 1'b0);
    end
    step(1'b1, 16'h5555, 2'b01, 1'b1, 16'h00F0, 2'b10, 1'b1, xa, xb);
    expect_out("bp_release", 1'b1, 32'h00F00000, 1'b1);
    step(1'b1, 16'h5555, 2'b01, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);

    // Random traffic; pending requests are held until accepted.
    pa = 1'b0; pb = 1'b0; ia = '0; ib = '0; ma = '0; mb = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pa) begin
        pa = 1'($urandom_range(0, 2) != 0); ia = 16'($urandom); ma = 2'($urandom);
      end
      if (!pb) begin
        pb = 1'($urandom_range(0, 2) != 0); ib = 16'($urandom); mb = 2'($urandom);
      end
      step(pa, ia, ma, pb, ib, mb, 1'($urandom_range(0, 3) != 0), xa, xb);
      if (xa) pa = 1'b0;
      if (xb) pb = 1'b0;
    end
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while a result is held.
    step(1'b1, 16'h7777, 2'b01, 1'b0, 16'h0, 2'b00, 1'b0, xa, xb);
    ReqA_Valid = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 1'b0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    model_reset();
    step(1'b1, 16'h0010, 2'b11, 1'b1, 16'h0, 2'b00, 1'b1, xa, xb);
    expect_out("post_rst", 1'b1, 32'h00000040, 1'b0);
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1, xa, xb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares one immediate-extension unit between two requesters: the decode stage (port A) and the branch/address-generation unit (port B). Each request supplies a 16-bit immediate and an extension mode. The block arbitrates round-robin, performs the extension, and presents the 32-bit result in a single output register with a valid/ready handshake. It sits between instruction decode and the ALU/branch-target datapath, replacing dedicated per-consumer extenders.

## Interface
Parameters:
- IN_W, 16, immediate input width (fixed at 16 for this design).
- OUT_W, 32, extended output width (fixed at 32 for this design).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqA_Valid  in  1  requester A has a request.
- ReqA_Imm  in  16  requester A immediate.
- ReqA_Mode  in  2  requester A extension mode.
- ReqA_Ready  out  1  A's request is accepted at this clock edge.
- ReqB_Valid  in  1  requester B has a request.
- ReqB_Imm  in  16  requester B immediate.
- ReqB_Mode  in  2  requester B extension mode.
- ReqB_Ready  out  1  B's request is accepted at this clock edge.
- Out_Valid  out  1  Out_Data/Out_Id hold a result.
- Out_Data  out  32  extended result.
- Out_Id  out  1  source of the result: 0 = A, 1 = B.
- Out_Ready  in  1  consumer takes the result at this edge.

## Operation
- Extension modes:
  - 00 sign-extend: {16{imm[15]}, imm}.
  - 01 zero-extend: {16'h0, imm}.
  - 10 upper: {imm, 16'h0}.
  - 11 branch offset: sign-extend, then shift left 2, i.e. {14{imm[15]}, imm, 2'b00}.
- Output register: single entry, two states.
  - EMPTY (Out_Valid=0).
  - FULL (Out_Valid=1).
- can_accept = !Out_Valid || Out_Ready.
- Arbitration:
  - 1-bit pointer `last` records the most recently granted requester.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than `last` is granted.
  - Ready is asserted only to the granted requester, and only when can_accept.
  - ReqX_Ready is combinational from the Valid inputs, Out_Valid and Out_Ready.
  - ReqX_Ready is never asserted while ReqX_Valid=0.
- Accept edge (granted and can_accept):
  - Out_Data is loaded with the extended immediate.
  - Out_Id is loaded with the grant.
  - Out_Valid is set to 1.
  - `last` is set to the grant.
- Drain edge (Out_Valid && Out_Ready) with no accept in the same cycle: Out_Valid goes to 0; Out_Data and Out_Id are retained.
- Drain and accept in the same cycle: the new result replaces the old one, Out_Valid stays 1, and there is no bubble.
- Requester rules:
  - A requester holds Valid, Imm and Mode stable until it sees Ready=1.
  - A requester must not withdraw a pending request.
  - The block does not check these rules.
- Invalid combinations: none. All four modes are legal.

## Timing
- Reset values while Rst_n=0: Out_Valid=0, Out_Data=32'h0, Out_Id=0, `last`=1 (so A wins the first contention). ReqA_Ready and ReqB_Ready evaluate to 0 when both Valid inputs are 0.
- Reset takes effect immediately, not at the next edge. Asserting Rst_n mid-operation drops Out_Valid at once and discards any held result.
- Latency: a request accepted at edge N appears on Out_Data with Out_Valid=1 after edge N, one cycle later.
- Throughput: one result per cycle while Out_Ready=1.
- Backpressure: while Out_Valid=1 and Out_Ready=0, Out_Data, Out_Id and Out_Valid are held unchanged, and both ReqX_Ready are 0.
- Fairness: under continuous contention, grants strictly alternate, so no requester waits more than one grant of the other.
- Out_Ready with Out_Valid=0 is ignored.

## Test plan
- Reset: hold Rst_n=0 with random inputs toggling, then release. Required: Out_Valid=0, Out_Data=0, Out_Id=0. Asserting Rst_n=0 mid-cycle while Out_Valid=1 drops Out_Valid before the next edge.
- Single request, mode 00: A only, Imm=16'h8001, Out_Ready=1. Required: ReqA_Ready=1 in the same cycle; the next cycle Out_Data=32'hFFFF8001, Out_Id=0, Out_Valid=1.
- Modes 01/10/11: B only with Imm=16'h8001 modes 01 and 10, then Imm=16'hFFFF mode 11. Required: results 32'h00008001, 32'h80010000 and 32'hFFFFFFFC, each with Out_Id=1. Also Imm=16'h0004 mode 11 gives 32'h00000010.
- Contention: both Valid held high for 4 cycles with Out_Ready=1, A Imm=16'h0001 and B Imm=16'h0002, both mode 01. Required: grant order A, B, A, B; Out_Data sequence 1, 2, 1, 2 on consecutive cycles with no bubbles.
- Backpressure: after one accept, Out_Ready=0 for 3 cycles while both requesters stay valid. Required: Out_Data and Out_Id frozen; ReqA_Ready=ReqB_Ready=0. When Out_Ready returns to 1, a drain and a new accept occur in the same cycle and Out_Valid stays 1.
- Idle drain: one accept, then no requests, with Out_Ready=1. Required: Out_Valid falls to 0 one cycle after the result appears, and Out_Data retains its last value.
